// File: rtl/codec_i2c_reg_writer.sv
// Codec register write sequencer: programs the Wishbone I2C master core after reset,
// then expands each 7-bit-register/9-bit-data codec write into paced I2C core register writes.
module codec_i2c_reg_writer #(
  parameter logic [15:0] PRESCALE = 16'h00C7,
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter logic [19:0] TIMEOUT  = 20'd200000
) (
  input  logic       clk,
  input  logic       reset,
  // A command transfers on a cycle where cmd_valid and cmd_ready are both high; fields are
  // captured only then. cmd_ready stays low from the cycle after accept until after cmd_done.
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_reg_addr,
  input  logic [8:0] cmd_data,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic       busy,
  output logic       wb_write,
  output logic [3:0] wb_address,
  output logic [7:0] wb_data,
  input  logic       wb_done,
  input  logic       i2c_irq,
  output logic [2:0] debug_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_WB  = 3'd2,
    ST_WAIT_IRQ = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] S_I0 = 4'd0;
  localparam logic [3:0] S_I2 = 4'd2;
  localparam logic [3:0] S_T0 = 4'd3;
  localparam logic [3:0] S_T1 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd7;
  localparam logic [3:0] S_T7 = 4'd10;
  localparam logic [3:0] S_T8 = 4'd11;
  localparam logic [3:0] S_A0 = 4'd12;

  localparam logic [3:0] REG_PRERLO = 4'd0;
  localparam logic [3:0] REG_PRERHI = 4'd1;
  localparam logic [3:0] REG_CTR    = 4'd2;
  localparam logic [3:0] REG_TXR    = 4'd3;
  localparam logic [3:0] REG_CR     = 4'd4;

  state_t      state, state_next;
  logic [3:0]  step, step_next;
  logic        err, err_next;
  logic [19:0] timer;
  logic [6:0]  reg_addr_q;
  logic [8:0]  data_q;
  logic [3:0]  step_address;
  logic [7:0]  step_data;
  logic        accept, done_ok, timed_out, irq_step, progress;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  // A completion in the same cycle as the request cannot belong to it.
  assign done_ok   = wb_done && !wb_write;
  assign timed_out = (timer == TIMEOUT - 20'd1);
  assign irq_step  = (step == S_T1) || (step == S_T4) || (step == S_T7);

  always_comb begin
    step_address = 4'd0;
    step_data    = 8'h00;
    case (step)
      4'd0:  begin step_address = REG_PRERLO; step_data = PRESCALE[7:0];         end
      4'd1:  begin step_address = REG_PRERHI; step_data = PRESCALE[15:8];        end
      4'd2:  begin step_address = REG_CTR;    step_data = 8'hC0;                 end
      4'd3:  begin step_address = REG_TXR;    step_data = {DEV_ADDR, 1'b0};      end
      4'd4:  begin step_address = REG_CR;     step_data = 8'h90;                 end
      4'd5:  begin step_address = REG_CR;     step_data = 8'h01;                 end
      4'd6:  begin step_address = REG_TXR;    step_data = {reg_addr_q, data_q[8]}; end
      4'd7:  begin step_address = REG_CR;     step_data = 8'h10;                 end
      4'd8:  begin step_address = REG_CR;     step_data = 8'h01;                 end
      4'd9:  begin step_address = REG_TXR;    step_data = data_q[7:0];           end
      4'd10: begin step_address = REG_CR;     step_data = 8'h50;                 end
      4'd11: begin step_address = REG_CR;     step_data = 8'h01;                 end
      4'd12: begin step_address = REG_CR;     step_data = 8'h41;                 end
      default: begin step_address = 4'd0;     step_data = 8'h00;                 end
    endcase
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    err_next   = err;
    progress   = ((state == ST_WAIT_WB) && done_ok) || ((state == ST_WAIT_IRQ) && i2c_irq);
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          step_next  = S_T0;
          err_next   = 1'b0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT_WB;
      ST_WAIT_WB, ST_WAIT_IRQ: begin
        if (progress) begin
          if (state == ST_WAIT_WB && irq_step) begin
            state_next = ST_WAIT_IRQ;
          end else if (state == ST_WAIT_WB && step == S_I2) begin
            state_next = ST_IDLE;
          end else if (state == ST_WAIT_WB && (step == S_T8 || step == S_A0)) begin
            state_next = ST_DONE;
          end else begin
            step_next  = step + 4'd1;
            state_next = ST_ISSUE;
          end
        end else if (timed_out) begin
          err_next = 1'b1;
          // Mid-transaction stalls try to release the bus; init or abort stalls just give up.
          if (step >= S_T0 && step != S_A0) begin
            step_next  = S_A0;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ISSUE;
      step       <= S_I0;
      err        <= 1'b0;
      timer      <= 20'd0;
      reg_addr_q <= 7'd0;
      data_q     <= 9'd0;
      wb_write   <= 1'b0;
      wb_address <= 4'd0;
      wb_data    <= 8'h00;
    end else begin
      state <= state_next;
      step  <= step_next;
      err   <= err_next;
      if (state_next != state) begin
        timer <= 20'd0;
      end else if (state == ST_WAIT_WB || state == ST_WAIT_IRQ) begin
        timer <= timer + 20'd1;
      end
      if (accept) begin
        reg_addr_q <= cmd_reg_addr;
        data_q     <= cmd_data;
      end
      wb_write <= (state == ST_ISSUE);
      if (state == ST_ISSUE) begin
        wb_address <= step_address;
        wb_data    <= step_data;
      end
    end
  end

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign cmd_done    = (state == ST_DONE) && (step >= S_T0);
  assign cmd_error   = err;
  assign debug_state = state;

endmodule
